// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: N-to-1 registered channel multiplexer with a ready/valid
// output stage. Manual mode forwards one selected channel per request; scan
// mode freezes all inputs into a snapshot and emits every channel in order,
// honouring downstream backpressure.
module mux_nto1_scan #(
  parameter  int N    = 16,
  parameter  int W    = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  In,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            start,
  output logic [W-1:0]    MuxOut,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            scan_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Scan index is one bit wider than a channel index so the last increment
  // (to N) never wraps back onto channel 0.
  localparam logic [SELW:0] LAST_CNT = (SELW+1)'(N - 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [SELW:0]   cnt_r;
  logic [N*W-1:0]  snap_r;
  logic [W-1:0]    muxout_r;
  logic [SELW-1:0] out_sel_r;
  logic            out_valid_r;
  logic            busy_r;
  logic            scan_done_r;

  logic            load_s;
  logic            in_ready_s;
  logic            manual_take_s;
  logic            scan_take_s;
  logic            start_scan_s;
  logic [W-1:0]    item_data_s;
  logic [SELW-1:0] item_sel_s;
  logic [SELW-1:0] cnt_idx_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: a scan only advances to DONE when the last channel is loaded.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_scan_s) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (load_s && (cnt_r == LAST_CNT)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode: handshake strobes and the item to be loaded this cycle.
  always_comb begin
    load_s        = !out_valid_r || out_ready;
    in_ready_s    = (state_r == IDLE) && !mode && load_s;
    manual_take_s = in_ready_s && in_valid;
    scan_take_s   = (state_r == SCAN) && load_s;
    start_scan_s  = (state_r == IDLE) && mode && start;
    cnt_idx_s     = cnt_r[SELW-1:0];
    if (scan_take_s) begin
      item_data_s = snap_r[int'(cnt_idx_s)*W +: W];
      item_sel_s  = cnt_idx_s;
    end else begin
      item_data_s = In[int'(sel)*W +: W];
      item_sel_s  = sel;
    end
  end

  // Datapath: snapshot capture, scan counter and the registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_r      <= '0;
      cnt_r       <= '0;
      muxout_r    <= '0;
      out_sel_r   <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      scan_done_r <= 1'b0;
    end else begin
      if (start_scan_s) begin
        snap_r <= In;
        cnt_r  <= '0;
      end else if (scan_take_s) begin
        cnt_r <= cnt_r + (SELW+1)'(1);
      end
      if (manual_take_s || scan_take_s) begin
        muxout_r    <= item_data_s;
        out_sel_r   <= item_sel_s;
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      // Status flags are registered copies of the upcoming state.
      busy_r      <= (state_nxt_s == SCAN);
      scan_done_r <= (state_nxt_s == DONE);
    end
  end

  assign in_ready  = in_ready_s;
  assign MuxOut    = muxout_r;
  assign out_sel   = out_sel_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign scan_done = scan_done_r;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb_mux_nto1_scan: scoreboard bench for mux_nto1_scan. Expected items are
// queued as stimulus is driven and retired when the DUT hands them over.
module tb_mux_nto1_scan;

  localparam int N     = 16;
  localparam int W     = 1;
  localparam int SELW  = 4;
  localparam int N2    = 4;
  localparam int W2    = 8;
  localparam int SELW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N*W-1:0]  In;
  logic [SELW-1:0] sel;
  logic            mode, in_valid, in_ready, start;
  logic [W-1:0]    MuxOut;
  logic [SELW-1:0] out_sel;
  logic            out_valid, out_ready, busy, scan_done;

  logic [N2*W2-1:0] In_w;
  logic [SELW2-1:0] sel_w;
  logic             mode_w, in_valid_w, in_ready_w, start_w;
  logic [W2-1:0]    MuxOut_w;
  logic [SELW2-1:0] out_sel_w;
  logic             out_valid_w, out_ready_w, busy_w, scan_done_w;

  mux_nto1_scan #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .In(In), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .start(start),
    .MuxOut(MuxOut), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .scan_done(scan_done)
  );

  mux_nto1_scan #(.N(N2), .W(W2)) dut_w (
    .clk(clk), .reset(reset), .In(In_w), .sel(sel_w), .mode(mode_w),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .start(start_w),
    .MuxOut(MuxOut_w), .out_sel(out_sel_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .busy(busy_w), .scan_done(scan_done_w)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int items    = 0;
  int items_w  = 0;
  int done_cnt = 0;
  int done_w   = 0;

  logic [SELW+W-1:0]   sb_q[$];
  logic [SELW2+W2-1:0] sbw_q[$];
  logic [SELW+W-1:0]   exp_v;
  logic [SELW2+W2-1:0] exp_vw;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 16x1 instance, retiring items on each handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          exp_v = sb_q.pop_front();
          check("item_data", 64'(MuxOut), 64'(exp_v[W-1:0]));
          check("item_sel", 64'(out_sel), 64'(exp_v[SELW+W-1:W]));
        end
        items++;
      end
      if (scan_done) done_cnt++;
    end
  end

  // Scoreboard for the 4x8 instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid_w && out_ready_w) begin
        if (sbw_q.size() == 0) begin
          check("sbw_underflow", 64'(sbw_q.size()), 64'd1);
        end else begin
          exp_vw = sbw_q.pop_front();
          check("w_item_data", 64'(MuxOut_w), 64'(exp_vw[W2-1:0]));
          check("w_item_sel", 64'(out_sel_w), 64'(exp_vw[SELW2+W2-1:W2]));
        end
        items_w++;
      end
      if (scan_done_w) done_w++;
    end
  end

  // Issue a scan trigger with value v; returns one cycle after the start edge
  // with In already changed, so only the snapshot can produce correct items.
  task automatic start_scan(input logic [N*W-1:0] v);
    In    = v;
    mode  = 1'b1;
    start = 1'b1;
    for (int i = 0; i < N; i++) sb_q.push_back({SELW'(i), v[i*W +: W]});
    tick();
    start = 1'b0;
    In    = ~v;
    check("scan_busy_on", 64'(busy), 64'd1);
    check("scan_no_item_yet", 64'(out_valid), 64'd0);
  endtask

  // Wait (bounded) for scan_done; checks latency, pulse width and idle return.
  task automatic run_to_done(input string tag, input int exp_cyc);
    int cyc;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (scan_done) break;
      @(posedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 64'(cyc < 200), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    tick();
    check({tag, "_done_low"}, 64'(scan_done), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [N*W-1:0] v;
    int d0;
    int cyc;
    reset = 1'b1; In = '0; sel = '0; mode = 1'b0; in_valid = 1'b0;
    start = 1'b0; out_ready = 1'b1;
    In_w = '0; sel_w = '0; mode_w = 1'b0; in_valid_w = 1'b0;
    start_w = 1'b0; out_ready_w = 1'b1;
    repeat (3) tick();
    check("rst_muxout", 64'(MuxOut), 64'd0);
    check("rst_out_sel", 64'(out_sel), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_scan_done", 64'(scan_done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    tick();

    // Manual mode, full throughput.
    In = 16'hC3B4;
    items = 0;
    for (int s = 0; s < N; s++) begin
      sel = SELW'(s);
      in_valid = 1'b1;
      sb_q.push_back({SELW'(s), In[s*W +: W]});
      check("man_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("man_valid_drop", 64'(out_valid), 64'd0);
    check("man_items", 64'(items), 64'd16);
    check("man_sb_empty", 64'(sb_q.size()), 64'd0);

    // Manual mode with backpressure: item held, no new request accepted.
    out_ready = 1'b0;
    sel = 4'd5;
    in_valid = 1'b1;
    sb_q.push_back({4'd5, In[5]});
    tick();
    check("man_bp_valid", 64'(out_valid), 64'd1);
    check("man_bp_ready", 64'(in_ready), 64'd0);
    sel = 4'd9;
    tick();
    check("man_bp_hold_sel", 64'(out_sel), 64'd5);
    check("man_bp_hold_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("man_bp_release", 64'(out_valid), 64'd0);

    // Scan with In changing right after start.
    items = 0; d0 = done_cnt;
    start_scan(16'hC3B4);
    In = 16'hFFFF;
    tick();
    check("scan_first_valid", 64'(out_valid), 64'd1);
    check("scan_first_sel", 64'(out_sel), 64'd0);
    run_to_done("scan", 15);
    check("scan_items", 64'(items), 64'd16);
    check("scan_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Scan with 5 cycles of backpressure on item 3.
    items = 0; d0 = done_cnt; v = 16'h5A3C;
    start_scan(v);
    repeat (4) tick();
    check("bp_pre_sel", 64'(out_sel), 64'd3);
    out_ready = 1'b0;
    repeat (5) begin
      In = 16'($urandom);
      tick();
      check("bp_hold_sel", 64'(out_sel), 64'd3);
      check("bp_hold_data", 64'(MuxOut), 64'(v[3]));
      check("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    run_to_done("bp", 12);
    check("bp_items", 64'(items), 64'd16);
    check("bp_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Ignored start, in_valid and mode changes during a scan.
    items = 0; d0 = done_cnt;
    start_scan(16'h96E1);
    in_valid = 1'b1; sel = 4'd3; mode = 1'b0; start = 1'b1;
    repeat (6) begin
      check("ign_in_ready", 64'(in_ready), 64'd0);
      check("ign_busy", 64'(busy), 64'd1);
      start = ~start;
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    run_to_done("ign", 10);
    check("ign_items", 64'(items), 64'd16);
    check("ign_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Reset mid-scan after item 7, then restart.
    items = 0; d0 = done_cnt;
    start_scan(16'hC3B4);
    repeat (8) tick();
    check("mid_pre_sel", 64'(out_sel), 64'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    check("mid_rst_muxout", 64'(MuxOut), 64'd0);
    check("mid_rst_out_sel", 64'(out_sel), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(scan_done), 64'd0);
    repeat (20) tick();
    check("mid_no_done", 64'(done_cnt - d0), 64'd0);
    items = 0;
    start_scan(16'hA55A);
    tick();
    check("restart_sel", 64'(out_sel), 64'd0);
    check("restart_valid", 64'(out_valid), 64'd1);
    run_to_done("restart", 15);
    check("restart_items", 64'(items), 64'd16);
    check("restart_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Wide-channel instance: N=4, W=8.
    items_w = 0;
    mode_w = 1'b1;
    In_w = 32'hDDCCBBAA;
    start_w = 1'b1;
    for (int i = 0; i < N2; i++) sbw_q.push_back({SELW2'(i), In_w[i*W2 +: W2]});
    tick();
    start_w = 1'b0;
    In_w = 32'h0;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      if (scan_done_w) break;
      @(posedge clk);
      cyc++;
    end
    check("w_latency", 64'(cyc), 64'd4);
    tick();
    check("w_items", 64'(items_w), 64'd4);
    check("w_done_pulses", 64'(done_w), 64'd1);
    check("w_busy_low", 64'(busy_w), 64'd0);
    check("w_sb_empty", 64'(sbw_q.size()), 64'd0);

    check("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
